// File: rtl/diag_pkg.sv
// Shared definitions for the diagnostics memory engine: opcodes, response codes,
// CRC-32 constants and the controller state encoding.
package diag_pkg;

  localparam logic [7:0] CmdHalt   = 8'hAA;
  localparam logic [7:0] CmdResume = 8'h55;
  localparam logic [7:0] CmdRead   = 8'h66;
  localparam logic [7:0] CmdConfig = 8'h77;
  localparam logic [7:0] CmdWrite  = 8'h99;

  localparam logic [7:0] RspAck = 8'hA5;
  localparam logic [7:0] RspNak = 8'hEE;

  localparam logic [31:0] CrcPoly = 32'hEDB88320;
  localparam logic [31:0] CrcInit = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    StIdle, StStartup, StRunning, StHalted, StHdr, StRdData, StWrData, StCrcOut
  } state_e;

  // Byte idx (3 = MSB) of the finished CRC, i.e. after the final inversion.
  function automatic logic [7:0] crc_tx_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] fin;
    fin = crc ^ 32'hFFFFFFFF;
    return fin[8*idx +: 8];
  endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational reflected CRC-32 update over one byte, computed bit-serially.
module crc32_byte
  import diag_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/diag_mem_engine.sv
// Byte-stream diagnostics controller: CPU halt/resume plus ranged memory read/write,
// each transfer closed by a CRC-32 trailer.
module diag_mem_engine
  import diag_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned CONFIG_WIDTH = 4,
  parameter int unsigned MEM_LATENCY  = 1
) (
  input  logic                    fpga_clk,
  input  logic                    fpga_reset,
  input  logic                    rx_dv,
  input  logic [7:0]              rx_byte,
  output logic                    tx_dv,
  output logic [7:0]              tx_byte,
  input  logic                    abort,
  output logic                    halt,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  input  logic [7:0]              mem_rdata,
  output logic [7:0]              mem_wdata,
  output logic                    mem_we,
  output logic                    mem_cs,
  input  logic [CONFIG_WIDTH-1:0] configuration,
  output logic [CONFIG_WIDTH-1:0] config_byte,
  output logic                    overrun
);

  localparam int unsigned AddrBytes = (ADDR_WIDTH + 7) / 8;
  localparam int unsigned HdrWidth  = AddrBytes * 8;
  localparam logic [2:0] HdrLast  = 3'(2 * AddrBytes - 1);
  localparam logic [2:0] AddrCnt  = 3'(AddrBytes);
  localparam logic [1:0] WaitInit = 2'(MEM_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] FullLen = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                  state_q, state_d;
  logic                    halt_q, halt_d, tx_dv_q, tx_dv_d;
  logic [7:0]              tx_byte_q, tx_byte_d, mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_we_q, mem_we_d, mem_cs_q, mem_cs_d;
  logic [CONFIG_WIDTH-1:0] config_q, config_d;
  logic                    overrun_q, overrun_d;
  logic [31:0]             crc_q, crc_d, crc_next;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
  logic [2:0]              hdr_cnt_q, hdr_cnt_d;
  logic [HdrWidth-1:0]     addr_sh_q, addr_sh_d, addr_shift, len_shift, len_sh_q, len_sh_d;
  logic [ADDR_WIDTH-1:0]   len_val;
  logic                    is_rd_q, is_rd_d, rd_pend_q, rd_pend_d;
  logic [1:0]              wait_q, wait_d, crc_idx_q, crc_idx_d;
  logic [7:0]              crc_data;
  logic                    active;

  assign crc_data   = rd_pend_q ? mem_rdata : rx_byte;
  assign addr_shift = HdrWidth'({addr_sh_q, rx_byte});
  assign len_shift  = HdrWidth'({len_sh_q, rx_byte});
  assign len_val    = len_shift[ADDR_WIDTH-1:0];
  assign active     = state_q inside {StHdr, StRdData, StWrData, StCrcOut};

  crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (crc_data),
    .crc_o  (crc_next)
  );

  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    tx_dv_d     = 1'b0;
    tx_byte_d   = tx_byte_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_cs_d    = mem_cs_q;
    config_d    = config_q;
    overrun_d   = overrun_q;
    crc_d       = crc_q;
    rem_d       = rem_q;
    hdr_cnt_d   = hdr_cnt_q;
    addr_sh_d   = addr_sh_q;
    len_sh_d    = len_sh_q;
    is_rd_d     = is_rd_q;
    rd_pend_d   = rd_pend_q;
    wait_d      = wait_q;
    crc_idx_d   = crc_idx_q;

    if (state_q == StIdle) begin
      config_d = configuration;
      state_d  = StStartup;
    end
    if (state_q == StStartup) state_d = StRunning;

    // A strobe just retired: step the address; after the final write, release the bus.
    if (mem_we_q) begin
      mem_addr_d = mem_addr_q + 1'b1;
      if (state_q != StWrData) mem_cs_d = 1'b0;
    end

    if (rd_pend_q) begin
      if (wait_q == '0) begin
        rd_pend_d = 1'b0;
        tx_dv_d   = 1'b1;
        tx_byte_d = mem_rdata;
        crc_d     = crc_next;
        rem_d     = rem_q - 1'b1;
      end else begin
        wait_d = wait_q - 1'b1;
      end
    end

    if (abort) begin
      if (active) begin
        mem_cs_d  = 1'b0;
        mem_we_d  = 1'b0;
        rd_pend_d = 1'b0;
        tx_dv_d   = 1'b0;
        state_d   = StHalted;
      end
    end else if (rx_dv) begin
      if (rd_pend_q) begin
        overrun_d = 1'b1;
      end else begin
        tx_dv_d   = 1'b1;
        tx_byte_d = RspNak;
        unique case (state_q)
          StRunning, StHalted: begin
            case (rx_byte)
              CmdHalt: begin
                halt_d = 1'b1; tx_byte_d = RspAck; state_d = StHalted;
              end
              CmdResume: begin
                halt_d = 1'b0; tx_byte_d = RspAck; state_d = StRunning;
              end
              CmdConfig: tx_byte_d = 8'(config_q);
              CmdRead, CmdWrite: begin
                if (state_q == StHalted) begin
                  tx_byte_d = RspAck;
                  is_rd_d   = (rx_byte == CmdRead);
                  hdr_cnt_d = '0;
                  crc_d     = CrcInit;
                  state_d   = StHdr;
                end
              end
              default: ;
            endcase
          end
          StHdr: begin
            tx_byte_d = 8'h00;
            hdr_cnt_d = hdr_cnt_q + 1'b1;
            if (hdr_cnt_q < AddrCnt) addr_sh_d = addr_shift;
            else                     len_sh_d  = len_shift;
            if (hdr_cnt_q == HdrLast) begin
              mem_cs_d   = 1'b1;
              mem_addr_d = addr_sh_q[ADDR_WIDTH-1:0];
              rem_d      = (len_val == '0) ? FullLen : {1'b0, len_val};
              if (is_rd_q) begin
                tx_dv_d   = 1'b0;
                rd_pend_d = 1'b1;
                wait_d    = WaitInit;
                state_d   = StRdData;
              end else begin
                state_d = StWrData;
              end
            end
          end
          StRdData: begin
            if (rem_q == '0) begin
              tx_byte_d = crc_tx_byte(crc_q, 2'd3);
              mem_cs_d  = 1'b0;
              crc_idx_d = 2'd2;
              state_d   = StCrcOut;
            end else begin
              tx_dv_d    = 1'b0;
              mem_addr_d = mem_addr_q + 1'b1;
              rd_pend_d  = 1'b1;
              wait_d     = WaitInit;
            end
          end
          StWrData: begin
            mem_wdata_d = rx_byte;
            mem_we_d    = 1'b1;
            crc_d       = crc_next;
            rem_d       = rem_q - 1'b1;
            tx_byte_d   = 8'h00;
            if (rem_q == {{ADDR_WIDTH{1'b0}}, 1'b1}) begin
              tx_byte_d = crc_tx_byte(crc_next, 2'd3);
              crc_idx_d = 2'd2;
              state_d   = StCrcOut;
            end
          end
          StCrcOut: begin
            tx_byte_d = crc_tx_byte(crc_q, crc_idx_q);
            if (crc_idx_q == 2'd0) state_d = StHalted;
            else                   crc_idx_d = crc_idx_q - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge fpga_clk or posedge fpga_reset) begin
    if (fpga_reset) begin
      state_q     <= StIdle;
      halt_q      <= 1'b0;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_cs_q    <= 1'b0;
      config_q    <= '0;
      overrun_q   <= 1'b0;
      crc_q       <= CrcInit;
      rem_q       <= '0;
      hdr_cnt_q   <= '0;
      addr_sh_q   <= '0;
      len_sh_q    <= '0;
      is_rd_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      wait_q      <= '0;
      crc_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_cs_q    <= mem_cs_d;
      config_q    <= config_d;
      overrun_q   <= overrun_d;
      crc_q       <= crc_d;
      rem_q       <= rem_d;
      hdr_cnt_q   <= hdr_cnt_d;
      addr_sh_q   <= addr_sh_d;
      len_sh_q    <= len_sh_d;
      is_rd_q     <= is_rd_d;
      rd_pend_q   <= rd_pend_d;
      wait_q      <= wait_d;
      crc_idx_q   <= crc_idx_d;
    end
  end

  assign halt        = halt_q;
  assign tx_dv       = tx_dv_q;
  assign tx_byte     = tx_byte_q;
  assign mem_address = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_cs      = mem_cs_q;
  assign config_byte = config_q;
  assign overrun     = overrun_q;

endmodule
